// File: rtl/flags_pkg.sv
// Shared types and constants for the flags-register update arbiter.
// Requester ids match the upd_src encoding seen by the flags register.
package flags_pkg;

  localparam int FLAGS_DATA_W = 8;

  typedef struct packed {
    logic [FLAGS_DATA_W-1:0] result;
    logic                    carry;
    logic                    overflow;
  } flag_upd_t;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } rr_state_e;

  localparam logic REQ_ALU   = 1'b0;
  localparam logic REQ_UCODE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic with its priority pointer.
// Grants are combinational; the pointer advances past whoever transferred.
module rr_arbiter2
  import flags_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic hold,
  output logic grant0,
  output logic grant1
);

  rr_state_e rr, rr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr <= PRI0;
    else     rr <= rr_nxt;
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    rr_nxt = rr;
    if (!hold) begin
      case (rr)
        PRI0: begin
          if (valid0)      grant0 = 1'b1;
          else if (valid1) grant1 = 1'b1;
        end
        PRI1: begin
          if (valid1)      grant1 = 1'b1;
          else if (valid0) grant0 = 1'b1;
        end
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
    end
    // A lone requester also hands priority to the other side after its turn.
    if (grant0)      rr_nxt = PRI1;
    else if (grant1) rr_nxt = PRI0;
  end

endmodule

// File: rtl/flags_update_arbiter.sv
// Shares the flags-register update port between the ALU and microcode paths,
// forwarding the winning payload through one registered output stage.
module flags_update_arbiter
  import flags_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_result,
  input  logic              req0_carry,
  input  logic              req0_overflow,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_result,
  input  logic              req1_carry,
  input  logic              req1_overflow,
  input  logic              hold,
  output logic              upd_valid,
  output logic [DATA_W-1:0] upd_result,
  output logic              upd_carry,
  output logic              upd_overflow,
  output logic              upd_src,
  output logic [CNT_W-1:0]  conflict_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              grant0, grant1;
  logic              vld_p0, src_p0, conflict_p0;
  logic [DATA_W-1:0] result_p0;
  logic              carry_p0, overflow_p0;

  logic              vld_p1, src_p1, carry_p1, overflow_p1;
  logic [DATA_W-1:0] result_p1;
  logic [CNT_W-1:0]  cnt_p1;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .hold   (hold),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // stage p0: grant decode and payload select
  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign vld_p0      = grant0 | grant1;
  assign src_p0      = grant1 ? REQ_UCODE : REQ_ALU;
  assign result_p0   = grant1 ? req1_result   : req0_result;
  assign carry_p0    = grant1 ? req1_carry    : req0_carry;
  assign overflow_p0 = grant1 ? req1_overflow : req0_overflow;
  assign conflict_p0 = req0_valid & req1_valid & ~hold;

  // stage p1: registered update towards the flags register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      src_p1      <= REQ_ALU;
      result_p1   <= '0;
      carry_p1    <= 1'b0;
      overflow_p1 <= 1'b0;
      cnt_p1      <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        src_p1      <= src_p0;
        result_p1   <= result_p0;
        carry_p1    <= carry_p0;
        overflow_p1 <= overflow_p0;
      end
      if (conflict_p0) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign upd_valid    = vld_p1;
  assign upd_result   = result_p1;
  assign upd_carry    = carry_p1;
  assign upd_overflow = overflow_p1;
  assign upd_src      = src_p1;
  assign conflict_cnt = cnt_p1;

endmodule

// File: tb/tb_flags_update_arbiter.sv
// Directed bench for flags_update_arbiter with a queue scoreboard of expected updates.
module tb_flags_update_arbiter;

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       src;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_carry, req0_overflow;
  logic [7:0] req0_result;
  logic       req1_valid, req1_ready, req1_carry, req1_overflow;
  logic [7:0] req1_result;
  logic       hold;
  logic       upd_valid, upd_carry, upd_overflow, upd_src;
  logic [7:0] upd_result;
  logic [7:0] conflict_cnt;

  int   checks = 0;
  int   failures = 0;
  int   n0 = 0;
  int   n1 = 0;
  exp_t q[$];
  exp_t last_m;
  bit   rr_m;
  int   cnt_m;

  flags_update_arbiter #(.DATA_W(8), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_result  (req0_result),
    .req0_carry   (req0_carry),
    .req0_overflow(req0_overflow),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_result  (req1_result),
    .req1_carry   (req1_carry),
    .req1_overflow(req1_overflow),
    .hold         (hold),
    .upd_valid    (upd_valid),
    .upd_result   (upd_result),
    .upd_carry    (upd_carry),
    .upd_overflow (upd_overflow),
    .upd_src      (upd_src),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_m = '0;
    rr_m   = 1'b0;
    cnt_m  = 0;
  endtask

  // One clock of stimulus: checks readies, scores the transfer, checks outputs after the edge.
  task automatic tick();
    bit   g0, g1;
    exp_t e;
    #1;
    g0 = !hold && req0_valid && (!req1_valid || rr_m == 1'b0);
    g1 = !hold && req1_valid && (!req0_valid || rr_m == 1'b1);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    if (g0) begin
      q.push_back('{req0_result, req0_carry, req0_overflow, 1'b0});
      rr_m = 1'b1;
    end else if (g1) begin
      q.push_back('{req1_result, req1_carry, req1_overflow, 1'b1});
      rr_m = 1'b0;
    end
    if (req0_valid && req1_valid && !hold && cnt_m < 255) cnt_m++;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("upd_valid_pulse", {31'd0, upd_valid}, 32'd1);
      chk("upd_result", {24'd0, upd_result}, {24'd0, e.result});
      chk("upd_carry", {31'd0, upd_carry}, {31'd0, e.carry});
      chk("upd_overflow", {31'd0, upd_overflow}, {31'd0, e.overflow});
      chk("upd_src", {31'd0, upd_src}, {31'd0, e.src});
      last_m = e;
      if (e.src) n1++; else n0++;
    end else begin
      chk("upd_valid_idle", {31'd0, upd_valid}, 32'd0);
      chk("upd_result_kept", {24'd0, upd_result}, {24'd0, last_m.result});
      chk("upd_src_kept", {31'd0, upd_src}, {31'd0, last_m.src});
    end
    chk("conflict_cnt", {24'd0, conflict_cnt}, cnt_m);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, upd_valid}, 32'd0);
    chk({tag, "_result"}, {24'd0, upd_result}, 32'd0);
    chk({tag, "_carry"}, {31'd0, upd_carry}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, upd_overflow}, 32'd0);
    chk({tag, "_src"}, {31'd0, upd_src}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, conflict_cnt}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive(input logic v0, input logic [7:0] r0, input logic c0, input logic o0,
                       input logic v1, input logic [7:0] r1, input logic c1, input logic o1,
                       input logic h);
    req0_valid = v0; req0_result = r0; req0_carry = c0; req0_overflow = o0;
    req1_valid = v1; req1_result = r1; req1_carry = c1; req1_overflow = o1;
    hold = h;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // req0 alone: zero result with carry
    drive(1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    tick();

    // both valid for 4 cycles from reset
    do_reset();
    drive(1, 8'h11, 0, 0, 1, 8'h22, 1, 1, 0);
    repeat (4) tick();
    chk("conflict_cnt_4", {24'd0, conflict_cnt}, 32'd4);

    // one more grant to requester 0 leaves priority with requester 1, then hold
    tick();
    drive(1, 8'h11, 0, 0, 1, 8'h22, 1, 1, 1);
    repeat (3) tick();
    chk("hold_cnt_frozen", {24'd0, conflict_cnt}, 32'd5);
    drive(1, 8'h11, 0, 0, 1, 8'h22, 1, 1, 0);
    #1;
    chk("release_gnt1", {31'd0, req1_ready}, 32'd1);
    tick();
    drive(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    tick();

    // requester 1 alone, then a conflict goes to requester 0
    drive(0, 8'h00, 0, 0, 1, 8'h80, 0, 1, 0);
    tick();
    drive(1, 8'h33, 1, 1, 1, 8'h44, 0, 0, 0);
    #1;
    chk("after_req1_gnt0", {31'd0, req0_ready}, 32'd1);
    tick();

    // reset while an update is registered
    drive(1, 8'h55, 1, 1, 0, 8'h00, 0, 0, 0);
    tick();
    chk("pre_rst_valid", {31'd0, upd_valid}, 32'd1);
    drive(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    do_reset();
    drive(1, 8'h66, 0, 1, 1, 8'h77, 1, 0, 0);
    #1;
    chk("post_rst_gnt0", {31'd0, req0_ready}, 32'd1);
    tick();

    // long conflict: saturation and fair alternation
    do_reset();
    n0 = 0;
    n1 = 0;
    drive(1, 8'hA5, 1, 0, 1, 8'h5A, 0, 1, 0);
    for (int i = 0; i < 300; i++) tick();
    chk("cnt_saturated", {24'd0, conflict_cnt}, 32'd255);
    chk("pulses_req0", n0, 32'd150);
    chk("pulses_req1", n1, 32'd150);
    drive(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    tick();
    chk("scoreboard_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
